mem_port_arbiter: RTL

//  Shares the single unified memory port between the IF stage (requester 0)
//  and the MEM stage (requester 1).
//  - Owns the select line of the 32-bit 2:1 address mux in front of the memory

---
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM requesters, the memory and the port arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if;
  logic req_if;
  logic req_mem;
  logic we_mem;
  logic mem_ready;
  logic sel;
  logic mem_req;
  logic mem_we;
  logic done_if;
  logic done_mem;
  logic stall_if;
  logic stall_mem;
  logic err_timeout;

  modport slave (
    input  req_if, req_mem, we_mem, mem_ready,
    output sel, mem_req, mem_we, done_if, done_mem, stall_if, stall_mem, err_timeout
  );

  modport master (
    output req_if, req_mem, we_mem, mem_ready,
    input  sel, mem_req, mem_we, done_if, done_mem, stall_if, stall_mem, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between IF (requester 0) and MEM (requester 1),
// with a starvation guard for IF and a per-access timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; arbitrate on this cycle's requests
// ACC_IF  | instruction read in flight, sel=0
// ACC_MEM | data access in flight, sel=1, mem_we latched at grant
module mem_port_arbiter #(
  parameter int MAX_STARVE = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC_IF = 2'd1, ACC_MEM = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          sel_q, sel_nxt;
  logic          we_q, we_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          in_acc;
  logic          if_starved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      sel_q      <= sel_nxt;
      we_q       <= we_nxt;
      starve_cnt <= starve_nxt;
      tmo_cnt    <= tmo_nxt;
    end
  end

  assign if_starved = bus.req_if && (starve_cnt == STARVE_MAX);

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_q;
    we_nxt     = we_q;
    starve_nxt = starve_cnt;
    tmo_nxt    = tmo_cnt;
    unique case (state)
      IDLE: begin
        if (bus.req_mem && !if_starved) begin
          state_nxt = ACC_MEM;
          sel_nxt   = 1'b1;
          we_nxt    = bus.we_mem;
          tmo_nxt   = '0;
          // MEM only wins against a waiting IF below the limit, so this saturates
          if (bus.req_if && (starve_cnt != STARVE_MAX))
            starve_nxt = starve_cnt + 1'b1;
        end else if (bus.req_if) begin
          state_nxt  = ACC_IF;
          sel_nxt    = 1'b0;
          we_nxt     = 1'b0;
          tmo_nxt    = '0;
          starve_nxt = '0;
        end
      end
      ACC_IF, ACC_MEM: begin
        if (bus.mem_ready || (tmo_cnt == TMO_LAST)) begin
          state_nxt = IDLE;
          we_nxt    = 1'b0;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        we_nxt    = 1'b0;
      end
    endcase
  end

  assign in_acc = (state == ACC_IF) || (state == ACC_MEM);

  always_comb begin
    bus.mem_req     = in_acc;
    bus.sel         = sel_q;
    bus.mem_we      = we_q;
    bus.done_if     = (state == ACC_IF) && bus.mem_ready;
    bus.done_mem    = (state == ACC_MEM) && bus.mem_ready;
    bus.err_timeout = in_acc && !bus.mem_ready && (tmo_cnt == TMO_LAST);
    bus.stall_if    = bus.req_if && !bus.done_if;
    bus.stall_mem   = bus.req_mem && !bus.done_mem;
  end

endmodule
